// File: rtl/phase_timer_bank.sv
// Bank of independent down-counting timer channels with one-shot or auto-reload
// modes, a global emergency preset and a registered 1->0 expiry pulse.

module phase_timer_chan #(
  parameter int BIT_WIDTH = 6,
  parameter int EMG_VALUE = 2**BIT_WIDTH-1
) (
  input  logic                 i_clk,
  input  logic                 i_resetN,
  input  logic                 i_enable,
  input  logic                 i_load,
  input  logic [BIT_WIDTH-1:0] i_loadIn,
  input  logic                 i_reloadMode,
  input  logic                 i_emgLoad,
  output logic [BIT_WIDTH-1:0] o_count,
  output logic                 o_expired
);
  localparam logic [BIT_WIDTH-1:0] EMG = BIT_WIDTH'(EMG_VALUE);
  localparam logic [BIT_WIDTH-1:0] ONE = BIT_WIDTH'(1);

  logic [BIT_WIDTH-1:0] r_count;
  logic [BIT_WIDTH-1:0] r_reload;
  logic                 r_expired;

  always_ff @(posedge i_clk) begin
    if (!i_resetN) begin
      r_count   <= '0;
      r_reload  <= '0;
      r_expired <= 1'b0;
    end else if (i_emgLoad) begin
      r_count   <= EMG;
      r_expired <= 1'b0;
    end else if (i_load) begin
      r_count   <= i_loadIn;
      r_reload  <= i_loadIn;
      r_expired <= 1'b0;
    end else if (i_enable) begin
      if (r_count > ONE) begin
        r_count   <= r_count - ONE;
        r_expired <= 1'b0;
      end else if (r_count == ONE) begin
        r_count   <= '0;
        r_expired <= 1'b1;
      end else begin
        // At zero: one-shot saturates, auto-reload restarts the period.
        if (i_reloadMode) r_count <= r_reload;
        r_expired <= 1'b0;
      end
    end else begin
      r_expired <= 1'b0;
    end
  end

  assign o_count   = r_count;
  assign o_expired = r_expired;
endmodule

module phase_timer_bank #(
  parameter int BIT_WIDTH = 6,
  parameter int CHANNELS  = 4,
  parameter int EMG_VALUE = 2**BIT_WIDTH-1
) (
  input  logic                          i_clk,
  input  logic                          i_resetN,
  input  logic [CHANNELS-1:0]           i_enable,
  input  logic [CHANNELS-1:0]           i_load,
  input  logic [CHANNELS*BIT_WIDTH-1:0] i_loadIn,
  input  logic [CHANNELS-1:0]           i_reloadMode,
  input  logic                          i_emgLoad,
  output logic [CHANNELS*BIT_WIDTH-1:0] o_currentCount,
  output logic [CHANNELS-1:0]           o_isZero,
  output logic [CHANNELS-1:0]           o_expired,
  output logic                          o_anyExpired
);
  logic [CHANNELS-1:0][BIT_WIDTH-1:0] w_count;
  logic [CHANNELS-1:0]                w_expired;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    phase_timer_chan #(
      .BIT_WIDTH (BIT_WIDTH),
      .EMG_VALUE (EMG_VALUE)
    ) u_chan (
      .i_clk        (i_clk),
      .i_resetN     (i_resetN),
      .i_enable     (i_enable[g]),
      .i_load       (i_load[g]),
      .i_loadIn     (i_loadIn[g*BIT_WIDTH +: BIT_WIDTH]),
      .i_reloadMode (i_reloadMode[g]),
      .i_emgLoad    (i_emgLoad),
      .o_count      (w_count[g]),
      .o_expired    (w_expired[g])
    );
    assign o_isZero[g] = (w_count[g] == '0);
  end

  assign o_currentCount = w_count;
  assign o_expired      = w_expired;
  assign o_anyExpired   = |w_expired;
endmodule

// File: doc/phase_timer_bank.md
PHASE_TIMER_BANK -- requirements
Module: phase_timer_bank

Interface
REQ-001 Parameter BIT_WIDTH, default 6, SHALL set the width of each channel counter.
REQ-002 Parameter CHANNELS, default 4, SHALL set the number of independent timer channels.
REQ-003 Parameter EMG_VALUE, default 2**BIT_WIDTH-1, SHALL set the value forced into every channel by emgLoad.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 resetN  input  1  SHALL be the synchronous, active-low reset.
REQ-006 enable  input  CHANNELS  SHALL be the per-channel count-down enable.
REQ-007 load  input  CHANNELS  SHALL be the per-channel load strobe.
REQ-008 loadIn  input  CHANNELS*BIT_WIDTH  SHALL carry the load values; channel i uses bits [i*BIT_WIDTH +: BIT_WIDTH].
REQ-009 reloadMode  input  CHANNELS  SHALL select the channel mode: 0 = one-shot saturating, 1 = auto-reload.
REQ-010 emgLoad  input  1  SHALL be the global emergency load affecting all channels.
REQ-011 currentCount  output  CHANNELS*BIT_WIDTH  SHALL be the registered count of each channel, packed like loadIn.
REQ-012 isZero  output  CHANNELS  SHALL be 1 when the channel count equals 0.
REQ-013 expired  output  CHANNELS  SHALL be a registered one-cycle pulse marking a channel's 1 -> 0 transition.
REQ-014 anyExpired  output  1  SHALL be the OR of all expired bits.

Function
REQ-015 Each channel SHALL hold a count register and a reload register, both BIT_WIDTH wide.
REQ-016 Per-channel priority at each edge SHALL be: reset > emgLoad > load[i] > enable[i] > hold.
REQ-017 On emgLoad=1, every count SHALL become EMG_VALUE, all expired bits SHALL be 0, and the reload registers SHALL remain unchanged.
REQ-018 On load[i]=1 (emgLoad=0), count[i] and reload[i] SHALL both take the channel's loadIn slice, and expired[i] SHALL be 0.
REQ-019 Loading 0 SHALL set isZero[i]=1 next cycle and SHALL NOT pulse expired[i].
REQ-020 If enable[i]=1 and count[i]>1, count[i] SHALL decrement by 1 per cycle.
REQ-021 If enable[i]=1 and count[i]=1, count[i] SHALL become 0 and expired[i] SHALL be 1 for exactly that following cycle.
REQ-022 If enable[i]=1, count[i]=0 and reloadMode[i]=0, count[i] SHALL saturate at 0 with no wrap to 2**BIT_WIDTH-1 and no further expired pulse.
REQ-023 If enable[i]=1, count[i]=0 and reloadMode[i]=1, count[i] SHALL take reload[i]; the zero state therefore lasts exactly one enabled cycle per period (period = reload+1 cycles).
REQ-024 In auto-reload with reload[i]=0, the channel SHALL stay at 0 and SHALL NOT pulse expired.
REQ-025 If enable[i]=0 and no load is active, count[i] SHALL hold, and expired[i] SHALL be 0 on the next cycle.
REQ-026 reloadMode[i] changes SHALL take effect at the next edge without disturbing count[i].
REQ-027 Channels SHALL be fully independent apart from emgLoad; simultaneous expiries SHALL each pulse their own bit.
REQ-028 isZero SHALL be combinational from the count register, giving zero added latency.

Reset
REQ-029 With resetN=0 at a rising edge, all counts, reload registers and expired bits SHALL become 0, which gives isZero = all ones and anyExpired = 0.
REQ-030 Reset SHALL override emgLoad, load and enable, including when asserted mid-count.
REQ-031 Before the first edge with resetN=0, all outputs SHALL be treated as undefined.

Verification
REQ-032 Reset, then load ch0=10 with reloadMode=0 and enable=1 -> count goes 10,9,...,1,0; expired[0] is high for exactly 1 cycle when the count reaches 0; the count then holds 0 with isZero[0]=1.
REQ-033 Load ch1=3 with reloadMode=1 and enable=1 -> count sequence 3,2,1,0,3,2,1,0; expired[1] pulses once per 4-cycle period.
REQ-034 ch2 counting at 20, then emgLoad=1 together with load[2]=1 and loadIn=5 -> all counts = 63, no expired pulse, reload[2] unchanged.
REQ-035 Load ch3=31, then drop enable[3] for 5 cycles at count 25 -> count holds 25; on re-enable it resumes at 24.
REQ-036 Assert resetN=0 mid-count on all channels -> next edge gives all counts 0, isZero=4'b1111, expired=0; a simultaneous load is ignored.
REQ-037 Expire ch0 and ch1 in the same cycle -> expired=4'b0011 and anyExpired=1 for one cycle; load 0 on any channel -> no pulse.
